pipeline_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage 16-bit core (IF/ID/EX/MEM/WB).
//  - Tracks pending register writes in a per-register scoreboard; stalls ID on RAW hazards.
//  - Flushes the wrong-path fetch on a taken jump resolved in ID.
//  - Drains and freezes the pipe on HLT.
//  - Drives every pipeline-register enable/flush and the PC enable.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 58 +++++
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the 5-stage core's hazard/sequencing controller.
package pipe_pkg;

  localparam int DEF_NREG   = 8;
  localparam int DEF_ADRW   = 3;
  localparam int DEF_WB_LAT = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  typedef logic [1:0] cnt_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with RAW hazard lookup for two ID sources.
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int ADRW = DEF_ADRW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_inc,
  input  logic [ADRW-1:0] i_inc_adr,
  input  logic            i_dec,
  input  logic [ADRW-1:0] i_dec_adr,
  input  logic [ADRW-1:0] i_src_a_adr,
  input  logic            i_src_a_use,
  input  logic [ADRW-1:0] i_src_b_adr,
  input  logic            i_src_b_use,
  output logic            o_haz,
  output logic [NREG-1:0] o_busy_mask
);

  logic [NREG-1:0] w_busy;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      cnt_t r_cnt;
      logic w_inc;
      logic w_dec;

      assign w_inc = i_inc && (i_inc_adr == ADRW'(gi));
      assign w_dec = i_dec && (i_dec_adr == ADRW'(gi));

      // A simultaneous issue and commit on the same register leaves the count unchanged.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec && r_cnt != 2'd3) begin
          r_cnt <= r_cnt + 2'd1;
        end else if (w_dec && !w_inc && r_cnt != 2'd0) begin
          r_cnt <= r_cnt - 2'd1;
        end
      end

      assign w_busy[gi] = |r_cnt;

      a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(w_dec && !w_inc && r_cnt == 2'd0));
      a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_inc && !w_dec && r_cnt == 2'd3));
    end
  endgenerate

  // No WB bypass: a commit in this cycle still reads as pending.
  assign o_haz = (i_src_a_use && w_busy[i_src_a_adr]) ||
                 (i_src_b_use && w_busy[i_src_b_adr]);
  assign o_busy_mask = w_busy;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: RAW stalls, jump flush, HLT drain/freeze and
// all pipeline-register enables for the IF/ID/EX/MEM/WB core.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int ADRW   = DEF_ADRW,
  parameter int WB_LAT = DEF_WB_LAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [ADRW-1:0] src_a_adr,
  input  logic            src_a_use,
  input  logic [ADRW-1:0] src_b_adr,
  input  logic            src_b_use,
  input  logic [ADRW-1:0] dst_adr,
  input  logic            dst_we,
  input  logic            jump_id,
  input  logic            halt_id,
  input  logic            ext_stall,
  input  logic            wb_we,
  input  logic [ADRW-1:0] wb_adr,
  output logic            issue,
  output logic            en_pc,
  output logic            en_ifid,
  output logic            flush_ifid,
  output logic            en_idex,
  output logic            flush_idex,
  output logic            en_exmem,
  output logic            flush_exmem,
  output logic            en_memwb,
  output logic            flush_memwb,
  output logic [NREG-1:0] busy_mask,
  output logic            halted
);

  localparam logic [1:0] DRAIN_LAST = 2'(WB_LAT - 1);

  pipe_state_t r_state, w_state_next;
  logic [1:0]  r_drain, w_drain_next;
  logic        w_haz;
  logic        w_all_idle;

  reg_scoreboard #(.NREG(NREG), .ADRW(ADRW)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (issue && dst_we),
    .i_inc_adr   (dst_adr),
    .i_dec       (wb_we && !ext_stall),
    .i_dec_adr   (wb_adr),
    .i_src_a_adr (src_a_adr),
    .i_src_a_use (src_a_use),
    .i_src_b_adr (src_b_adr),
    .i_src_b_use (src_b_use),
    .o_haz       (w_haz),
    .o_busy_mask (busy_mask)
  );

  assign w_all_idle = (busy_mask == '0);
  assign issue      = !reset && id_valid && !w_haz && !ext_stall && (r_state == RUN);
  assign halted     = (r_state == HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_drain <= 2'd0;
    end else if (!ext_stall) begin
      r_state <= w_state_next;
      r_drain <= w_drain_next;
    end
  end

  // The drain counter saturates so the exit condition holds until the scoreboard empties.
  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain;
    case (r_state)
      RUN: begin
        if (issue && halt_id) begin
          w_state_next = DRAIN;
          w_drain_next = 2'd0;
        end
      end
      DRAIN: begin
        if (r_drain == DRAIN_LAST && w_all_idle) begin
          w_state_next = HALTED;
        end else if (r_drain != DRAIN_LAST) begin
          w_drain_next = r_drain + 2'd1;
        end
      end
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    en_pc       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    if (reset) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else if (ext_stall || r_state == HALTED) begin
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
    end else if (r_state == DRAIN || (id_valid && w_haz)) begin
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      flush_idex = 1'b1;
    end else if (issue && jump_id) begin
      flush_ifid = 1'b1;
    end else if (issue && halt_id) begin
      en_pc   = 1'b0;
      en_ifid = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: RAW stalls, jumps, HLT drain, ext_stall freeze, reset.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, src_a_use, src_b_use, dst_we, jump_id, halt_id, ext_stall, wb_we;
  logic [2:0] src_a_adr, src_b_adr, dst_adr, wb_adr;
  logic       issue, en_pc, en_ifid, flush_ifid, en_idex, flush_idex;
  logic       en_exmem, flush_exmem, en_memwb, flush_memwb, halted;
  logic [7:0] busy_mask;
  logic [8:0] ctl;

  int n_chk = 0;
  int n_err = 0;

  // {en_pc,en_ifid,en_idex,en_exmem,en_memwb, flush_ifid,flush_idex,flush_exmem,flush_memwb}
  localparam logic [8:0] C_RUN   = 9'b11111_0000;
  localparam logic [8:0] C_STALL = 9'b00111_0100;
  localparam logic [8:0] C_JUMP  = 9'b11111_1000;
  localparam logic [8:0] C_HLT   = 9'b00111_0000;
  localparam logic [8:0] C_FRZ   = 9'b00000_0000;
  localparam logic [8:0] C_RST   = 9'b11111_1111;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .src_a_adr(src_a_adr), .src_a_use(src_a_use),
    .src_b_adr(src_b_adr), .src_b_use(src_b_use),
    .dst_adr(dst_adr), .dst_we(dst_we), .jump_id(jump_id), .halt_id(halt_id),
    .ext_stall(ext_stall), .wb_we(wb_we), .wb_adr(wb_adr),
    .issue(issue), .en_pc(en_pc), .en_ifid(en_ifid), .flush_ifid(flush_ifid),
    .en_idex(en_idex), .flush_idex(flush_idex), .en_exmem(en_exmem),
    .flush_exmem(flush_exmem), .en_memwb(en_memwb), .flush_memwb(flush_memwb),
    .busy_mask(busy_mask), .halted(halted)
  );

  assign ctl = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                flush_ifid, flush_idex, flush_exmem, flush_memwb};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic idle_in();
    id_valid = 0; src_a_use = 0; src_b_use = 0; dst_we = 0;
    jump_id = 0; halt_id = 0; ext_stall = 0; wb_we = 0;
    src_a_adr = 0; src_b_adr = 0; dst_adr = 0; wb_adr = 0;
  endtask

  // Advance one clock, then leave inputs settle well away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue_wr(input logic [2:0] r, input string tag);
    id_valid = 1; dst_we = 1; dst_adr = r;
    settle();
    chk(tag, issue, 1'b1);
    cyc();
  endtask

  initial begin
    idle_in();
    reset = 1;
    #1;
    settle();
    chk("rst_ctl", ctl, C_RST);
    chk("rst_issue", issue, 1'b0);
    cyc();
    reset = 0;
    settle();
    chk("post_rst_busy", busy_mask, 8'h00);
    chk("post_rst_halted", halted, 1'b0);
    chk("post_rst_ctl", ctl, C_RUN);

    // 1: write r1 then read r1 -> three stall cycles, WB commit in the third
    issue_wr(3'd1, "t1_wr_issue");
    for (int k = 0; k < 3; k++) begin
      id_valid = 1; src_a_use = 1; src_a_adr = 3'd1;
      wb_we = (k == 2); wb_adr = 3'd1;
      settle();
      chk($sformatf("t1_stall%0d_ctl", k), ctl, C_STALL);
      chk($sformatf("t1_stall%0d_issue", k), issue, 1'b0);
      cyc();
    end
    id_valid = 1; src_a_use = 1; src_a_adr = 3'd1;
    settle();
    chk("t1_issue", issue, 1'b1);
    chk("t1_busy", busy_mask, 8'h00);
    chk("t1_ctl", ctl, C_RUN);
    cyc();

    // 2: two writes to r2, read must wait for both commits
    issue_wr(3'd2, "t2_wr0");
    issue_wr(3'd2, "t2_wr1");
    for (int k = 0; k < 3; k++) begin
      id_valid = 1; src_b_use = 1; src_b_adr = 3'd2;
      wb_we = (k != 0); wb_adr = 3'd2;
      settle();
      chk($sformatf("t2_stall%0d_ctl", k), ctl, C_STALL);
      chk($sformatf("t2_stall%0d_busy", k), busy_mask, 8'h04);
      cyc();
    end
    id_valid = 1; src_b_use = 1; src_b_adr = 3'd2;
    settle();
    chk("t2_issue", issue, 1'b1);
    chk("t2_busy", busy_mask, 8'h00);
    cyc();

    // 3: jump without hazard, then jump blocked by a hazard on r6
    id_valid = 1; jump_id = 1;
    settle();
    chk("t3_jump_ctl", ctl, C_JUMP);
    chk("t3_jump_issue", issue, 1'b1);
    cyc();
    issue_wr(3'd6, "t3_wr6");
    for (int k = 0; k < 2; k++) begin
      id_valid = 1; jump_id = 1; src_a_use = 1; src_a_adr = 3'd6;
      wb_we = (k == 1); wb_adr = 3'd6;
      settle();
      chk($sformatf("t3_hjump%0d_ctl", k), ctl, C_STALL);
      cyc();
    end
    id_valid = 1; jump_id = 1; src_a_use = 1; src_a_adr = 3'd6;
    settle();
    chk("t3_jump2_ctl", ctl, C_JUMP);
    chk("t3_jump2_issue", issue, 1'b1);
    cyc();

    // 4: HLT with r3 pending; commit delayed so drain must wait on the scoreboard
    issue_wr(3'd3, "t4_wr3");
    id_valid = 1; halt_id = 1;
    settle();
    chk("t4_hlt_issue", issue, 1'b1);
    chk("t4_hlt_ctl", ctl, C_HLT);
    cyc();
    for (int k = 0; k < 5; k++) begin
      wb_we = (k == 3); wb_adr = 3'd3;
      settle();
      chk($sformatf("t4_drain%0d_ctl", k), ctl, C_STALL);
      chk($sformatf("t4_drain%0d_halted", k), halted, 1'b0);
      cyc();
    end
    id_valid = 1;
    settle();
    chk("t4_halted", halted, 1'b1);
    chk("t4_halt_ctl", ctl, C_FRZ);
    chk("t4_halt_issue", issue, 1'b0);
    cyc();
    reset = 1;
    settle();
    chk("t4_rst_ctl", ctl, C_RST);
    cyc();
    reset = 0;

    // 5: ext_stall freezes everything, including WB decrements
    issue_wr(3'd4, "t5_wr4");
    for (int k = 0; k < 4; k++) begin
      ext_stall = 1; wb_we = 1; wb_adr = 3'd4;
      id_valid = (k == 0); dst_we = 1; dst_adr = 3'd5;
      settle();
      chk($sformatf("t5_frz%0d_ctl", k), ctl, C_FRZ);
      chk($sformatf("t5_frz%0d_busy", k), busy_mask, 8'h10);
      chk($sformatf("t5_frz%0d_issue", k), issue, 1'b0);
      cyc();
    end
    wb_we = 1; wb_adr = 3'd4;
    settle();
    chk("t5_rel_ctl", ctl, C_RUN);
    chk("t5_rel_busy", busy_mask, 8'h10);
    cyc();
    settle();
    chk("t5_done_busy", busy_mask, 8'h00);
    cyc();

    // 6: reset during DRAIN with r2/r3 pending
    issue_wr(3'd2, "t6_wr2");
    issue_wr(3'd3, "t6_wr3");
    id_valid = 1; halt_id = 1;
    settle();
    chk("t6_hlt_issue", issue, 1'b1);
    cyc();
    settle();
    chk("t6_drain_ctl", ctl, C_STALL);
    chk("t6_drain_busy", busy_mask, 8'h0C);
    cyc();
    reset = 1; id_valid = 1;
    settle();
    chk("t6_rst_ctl", ctl, C_RST);
    chk("t6_rst_issue", issue, 1'b0);
    cyc();
    reset = 0;
    id_valid = 1; src_a_use = 1; src_a_adr = 3'd2;
    settle();
    chk("t6_busy", busy_mask, 8'h00);
    chk("t6_halted", halted, 1'b0);
    chk("t6_run_issue", issue, 1'b1);
    chk("t6_run_ctl", ctl, C_RUN);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
